// File: rtl/ysyx_muldiv_pkg.sv
// Shared definitions for the M-extension execute unit: funct3 codes, FSM states, helpers.
package ysyx_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/ysyx_exu_div_step.sv
// One restoring-divide step on magnitudes: shift in the next dividend bit, subtract if it fits.
module ysyx_exu_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN:0]   o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN+1:0] w_sh;
  logic [XLEN+1:0] w_diff;
  logic            w_ge;

  // Extra top bit turns the subtraction borrow into the compare result.
  assign w_sh   = {i_rem, i_quo[XLEN-1]};
  assign w_diff = w_sh - {2'b00, i_div};
  assign w_ge   = ~w_diff[XLEN+1];
  assign o_rem  = w_ge ? w_diff[XLEN:0] : w_sh[XLEN:0];
  assign o_quo  = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/ysyx_exu_muldiv.sv
// Multi-cycle RV M-extension unit: shift-add multiply / restoring divide, UNROLL bits per cycle,
// single op in flight with valid/ready on both sides and speculative flush.
module ysyx_exu_muldiv
  import ysyx_muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy_o
);

  localparam int unsigned STEPS = XLEN / UNROLL;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e r_state, w_state_nxt;
  logic   r_out_valid, r_busy;

  logic [2:0]       r_f3;
  logic [TAG_W-1:0] r_tag;
  logic             r_neg_q, r_neg_r;
  logic [XLEN-1:0]  r_opb;
  logic [XLEN:0]    r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_result;

  logic             w_accept;
  logic             w_s1_signed, w_s2_signed, w_neg1, w_neg2;
  logic [XLEN-1:0]  w_abs1, w_abs2;
  logic             w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]  w_special_res;

  logic [XLEN:0]    w_mhi, w_msum;
  logic [XLEN-1:0]  w_mlo;
  logic [XLEN:0]    w_drem;
  logic [XLEN-1:0]  w_dquo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]  w_quo_s, w_rem_s, w_calc_res;

  assign in_ready   = (r_state == IDLE) & ~flush & rst;
  assign w_accept   = in_valid & in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_tag    = r_tag;
  assign busy_o     = r_busy;

  // Operand decode: signedness, magnitudes and the divide shortcuts.
  always_comb begin
    w_s1_signed = (in_funct3 == F3_MULH) | (in_funct3 == F3_MULHSU) |
                  (in_funct3 == F3_DIV)  | (in_funct3 == F3_REM);
    w_s2_signed = (in_funct3 == F3_MULH) | (in_funct3 == F3_DIV) | (in_funct3 == F3_REM);
    w_neg1      = w_s1_signed & in_src1[XLEN-1];
    w_neg2      = w_s2_signed & in_src2[XLEN-1];
    w_abs1      = w_neg1 ? -in_src1 : in_src1;
    w_abs2      = w_neg2 ? -in_src2 : in_src2;
    w_div_zero  = is_div(in_funct3) & (in_src2 == '0);
    w_div_ovf   = ((in_funct3 == F3_DIV) | (in_funct3 == F3_REM)) &
                  (in_src1 == MIN_INT) & (in_src2 == '1);
    w_special   = w_div_zero | w_div_ovf;
    w_special_res = '0;
    if (w_div_zero) w_special_res = in_funct3[1] ? in_src1 : '1;
    else            w_special_res = in_funct3[1] ? '0 : in_src1;
  end

  // Shift-add multiply: upper half accumulates, lower half shifts the multiplier out.
  always_comb begin
    w_mhi  = r_hi;
    w_mlo  = r_lo;
    w_msum = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      w_msum = {1'b0, w_mhi[XLEN-1:0]} + (w_mlo[0] ? {1'b0, r_opb} : '0);
      w_mhi  = {1'b0, w_msum[XLEN:1]};
      w_mlo  = {w_msum[0], w_mlo[XLEN-1:1]};
    end
  end

  for (genvar g = 0; g < UNROLL; g++) begin : g_div
    logic [XLEN:0]   w_rem_i, w_rem_o;
    logic [XLEN-1:0] w_quo_i, w_quo_o;
    if (g == 0) begin : g_first
      assign w_rem_i = r_hi;
      assign w_quo_i = r_lo;
    end else begin : g_next
      assign w_rem_i = g_div[g-1].w_rem_o;
      assign w_quo_i = g_div[g-1].w_quo_o;
    end
    ysyx_exu_div_step #(.XLEN(XLEN)) u_step (
      .i_rem (w_rem_i),
      .i_quo (w_quo_i),
      .i_div (r_opb),
      .o_rem (w_rem_o),
      .o_quo (w_quo_o)
    );
  end

  assign w_drem = g_div[UNROLL-1].w_rem_o;
  assign w_dquo = g_div[UNROLL-1].w_quo_o;

  // Sign correction on the final iteration; the product is negated at full width.
  always_comb begin
    w_prod = {w_mhi[XLEN-1:0], w_mlo};
    if (r_neg_q) w_prod = -w_prod;
    w_quo_s = r_neg_q ? -w_dquo : w_dquo;
    w_rem_s = r_neg_r ? -w_drem[XLEN-1:0] : w_drem[XLEN-1:0];
    if (is_div(r_f3)) w_calc_res = r_f3[1] ? w_rem_s : w_quo_s;
    else              w_calc_res = (r_f3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // Operand/iteration datapath; multiply and divide share the hi/lo/opb registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_f3     <= '0;
      r_tag    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_f3    <= in_funct3;
      r_tag   <= in_tag;
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
      r_hi    <= '0;
      r_cnt   <= w_special ? '0 : CNT_W'(STEPS);
      if (is_div(in_funct3)) begin
        r_lo  <= w_abs1;
        r_opb <= w_abs2;
      end else begin
        r_lo  <= w_abs2;
        r_opb <= w_abs1;
      end
      if (w_special) r_result <= w_special_res;
    end else if (r_state == CALC) begin
      r_hi  <= is_div(r_f3) ? w_drem : w_mhi;
      r_lo  <= is_div(r_f3) ? w_dquo : w_mlo;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_result <= w_calc_res;
    end
  end

endmodule
